// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename tags.
// Each register holds a committed value and the ROB tag of its pending
// producer (0 = value ready). Issue renames, commit writes back and releases
// the tag if it still matches, and flush drops all speculative tags.

// One architectural register: committed value plus pending-producer tag.
module rename_reg_entry #(
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 issue_hit,
  input  logic [TAG_WIDTH-1:0] issue_tag,
  input  logic                 commit_hit,
  input  logic [VAL_WIDTH-1:0] commit_res,
  input  logic [TAG_WIDTH-1:0] commit_lab,
  output logic [VAL_WIDTH-1:0] val,
  output logic [TAG_WIDTH-1:0] lab
);

  // Committed value: commit is architectural, so it lands even under flush.
  always_ff @(posedge clk) begin
    if (rst_in)
      val <= '0;
    else if (rdy_in && commit_hit)
      val <= commit_res;
  end

  // Tag: flush clears everything, a new issue beats a same-cycle release,
  // and a commit only releases the tag if it is still the latest producer.
  always_ff @(posedge clk) begin
    if (rst_in)
      lab <= '0;
    else if (rdy_in) begin
      if (flush)
        lab <= '0;
      else if (issue_hit)
        lab <= issue_tag;
      else if (commit_hit && (lab == commit_lab))
        lab <= '0;
    end
  end

endmodule

// Combinational read port with commit bypass.
module rename_reg_rdport #(
  parameter int REG_COUNT = 32,
  parameter int REG_WIDTH = 5,
  parameter int VAL_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic [REG_COUNT-1:0][VAL_WIDTH-1:0] val_q,
  input  logic [REG_COUNT-1:0][TAG_WIDTH-1:0] lab_q,
  input  logic [REG_WIDTH-1:0]                rs,
  input  logic                                commit_en,
  input  logic [REG_WIDTH-1:0]                commit_rd,
  input  logic [VAL_WIDTH-1:0]                commit_res,
  input  logic [TAG_WIDTH-1:0]                commit_lab,
  output logic [TAG_WIDTH-1:0]                rf_label,
  output logic [VAL_WIDTH-1:0]                rf_val
);

  logic [TAG_WIDTH-1:0] lab_rd;
  logic [VAL_WIDTH-1:0] val_rd;
  logic                 bypass;

  // Entry 0 is tied to zero, so rs==0 reads 0/0 without a special case here;
  // the explicit rs check only keeps a stray x0 commit from bypassing.
  always_comb begin
    lab_rd = lab_q[rs];
    val_rd = val_q[rs];
    bypass = commit_en && (commit_rd == rs) && (rs != '0) &&
             (lab_rd == commit_lab);
    rf_label = bypass ? '0 : lab_rd;
    rf_val   = bypass ? commit_res : val_rd;
  end

endmodule

// Top: register array plus two read ports.
module rename_reg_file #(
  parameter int REG_COUNT    = 32,
  parameter int REG_WIDTH    = 5,
  parameter int VAL_WIDTH    = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_en,
  input  logic [REG_WIDTH-1:0]    issue_rd,
  input  logic [ROB_ID_WIDTH:0]   issue_tag,
  input  logic [REG_WIDTH-1:0]    rs1,
  input  logic [REG_WIDTH-1:0]    rs2,
  input  logic                    commit_en,
  input  logic [REG_WIDTH-1:0]    commit_rd,
  input  logic [VAL_WIDTH-1:0]    commit_res,
  input  logic [ROB_ID_WIDTH:0]   commit_lab,
  input  logic                    flush,
  output logic [ROB_ID_WIDTH:0]   rf_label1,
  output logic [ROB_ID_WIDTH:0]   rf_label2,
  output logic [VAL_WIDTH-1:0]    rf_val1,
  output logic [VAL_WIDTH-1:0]    rf_val2
);

  localparam int TAG_WIDTH = ROB_ID_WIDTH + 1;

  logic [REG_COUNT-1:0][VAL_WIDTH-1:0] val_q;
  logic [REG_COUNT-1:0][TAG_WIDTH-1:0] lab_q;

  // x0 is hardwired: no storage, always reads value 0 and tag 0.
  assign val_q[0] = '0;
  assign lab_q[0] = '0;

  genvar i;
  generate
    for (i = 1; i < REG_COUNT; i++) begin : g_reg
      logic issue_hit;
      logic commit_hit;

      // Per-register decode of the shared issue/commit buses.
      always_comb begin
        issue_hit  = issue_en  && (issue_rd  == REG_WIDTH'(i));
        commit_hit = commit_en && (commit_rd == REG_WIDTH'(i));
      end

      rename_reg_entry #(
        .VAL_WIDTH (VAL_WIDTH),
        .TAG_WIDTH (TAG_WIDTH)
      ) u_entry (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .flush      (flush),
        .issue_hit  (issue_hit),
        .issue_tag  (issue_tag),
        .commit_hit (commit_hit),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .val        (val_q[i]),
        .lab        (lab_q[i])
      );
    end
  endgenerate

  rename_reg_rdport #(
    .REG_COUNT (REG_COUNT),
    .REG_WIDTH (REG_WIDTH),
    .VAL_WIDTH (VAL_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rd1 (
    .val_q      (val_q),
    .lab_q      (lab_q),
    .rs         (rs1),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_res (commit_res),
    .commit_lab (commit_lab),
    .rf_label   (rf_label1),
    .rf_val     (rf_val1)
  );

  rename_reg_rdport #(
    .REG_COUNT (REG_COUNT),
    .REG_WIDTH (REG_WIDTH),
    .VAL_WIDTH (VAL_WIDTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rd2 (
    .val_q      (val_q),
    .lab_q      (lab_q),
    .rs         (rs2),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_res (commit_res),
    .commit_lab (commit_lab),
    .rf_label   (rf_label2),
    .rf_val     (rf_val2)
  );

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tags. It is the receiving end of the ROB commit interface (commit_en/commit_rd/commit_res/commit_lab) and the source of the ROB's operand lookup (rf_label1/2, rf_val1/2).
- At issue it records which ROB tag will produce each destination register.
- At commit it writes the value and releases the tag.
- On flush it drops all speculative tags.

Parameters:
- REG_COUNT, 32, number of architectural registers; x0 hardwired to zero.
- REG_WIDTH, 5, register index width.
- VAL_WIDTH, 32, data width.
- ROB_ID_WIDTH, 4, ROB index width. Tags are ROB_ID_WIDTH+1 bits, valid range 1..2^ROB_ID_WIDTH; tag 0 means "no pending producer".

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state holds.
- issue_en  in  1  decoder issues an instruction this cycle.
- issue_rd  in  REG_WIDTH  destination of the issuing instruction.
- issue_tag  in  ROB_ID_WIDTH+1  ROB tag assigned to the issuing instruction (the ROB's newTag).
- rs1  in  REG_WIDTH  source 1 index of the issuing instruction.
- rs2  in  REG_WIDTH  source 2 index.
- commit_en  in  1  ROB commits a register write.
- commit_rd  in  REG_WIDTH  committed destination.
- commit_res  in  VAL_WIDTH  committed value.
- commit_lab  in  ROB_ID_WIDTH+1  tag of the committing entry.
- flush  in  1  misprediction flush from the ROB.
- rf_label1  out  ROB_ID_WIDTH+1  pending tag for rs1; 0 if value ready.
- rf_label2  out  ROB_ID_WIDTH+1  pending tag for rs2.
- rf_val1  out  VAL_WIDTH  architectural value of rs1.
- rf_val2  out  VAL_WIDTH  architectural value of rs2.

Behaviour:
- State: val[0..REG_COUNT-1], lab[0..REG_COUNT-1].
- Reset (rst_in=1 at posedge, regardless of rdy_in): all val=0, all lab=0. Outputs are combinational and therefore read 0 during and after reset until a write.
- rdy_in=0 with rst_in=0: no state change; commit/issue/flush ignored.
- Read ports: combinational, zero latency.
  - rf_labelN = lab[rsN] and rf_valN = val[rsN], with commit bypass.
  - Bypass: if commit_en && commit_rd==rsN && commit_rd!=0 && lab[rsN]==commit_lab, then rf_labelN=0 and rf_valN=commit_res.
  - If commit_rd matches but the tag differs (a younger producer is pending), rf_labelN stays lab[rsN]; rf_valN may show commit_res (don't-care while label is nonzero).
  - rsN==0 always gives label 0, value 0.
  - The same-cycle issue rename never affects the read ports. Sources of the issuing instruction see pre-issue state, so an instruction with rs1==rd reads the old producer.
- Commit (commit_en=1, commit_rd!=0): val[commit_rd] <= commit_res. lab[commit_rd] <= 0 only if lab[commit_rd]==commit_lab and not overwritten by the same-cycle issue rule below.
- Issue (issue_en=1, issue_rd!=0, flush=0): lab[issue_rd] <= issue_tag.
- Issue and commit to the same register in the same cycle: the issue tag wins for lab; val still takes commit_res.
- Flush=1: all lab <= 0 and issue is ignored. A commit in the same cycle still writes val, because commit is architectural.
- Writes and renames to x0 are discarded; val[0] and lab[0] stay 0 permanently.
- Tag wrap: tags are compared by equality only. Tag 2^ROB_ID_WIDTH is a legal nonzero tag and receives no special treatment.
- No handshake and no backpressure: every enabled event completes in the cycle it is presented.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> labels 0/0, values 0/0.
- Issue rd=3 tag=2; next cycle read rs1=3 -> label 2. Commit rd=3 res=0xDEAD lab=2 -> same-cycle read shows label 0, val 0xDEAD; after the edge lab[3]=0, val[3]=0xDEAD.
- Issue rd=4 tag=1, then issue rd=4 tag=5, then commit rd=4 lab=1 res=7 -> val[4]=7, lab[4] stays 5; read rs1=4 gives label 5.
- Same cycle: commit rd=6 lab=3 res=9 and issue rd=6 tag=8, with lab[6]=3 beforehand -> lab[6]=8, val[6]=9. Issue of rs1=6 in that cycle reads label 0, val 9 via bypass.
- Labels pending on x1 (tag 4) and x2 (tag 16). Flush together with issue rd=7 tag=9 and commit rd=1 lab=4 res=11 -> all labels 0, lab[7]=0, val[1]=11.
- Write to x0 via issue (tag 3) and commit (res 5) -> val[0]=0, lab[0]=0. With rdy_in=0, issue rd=2 tag=1 -> lab[2] unchanged.
